ef_i2s_tdm_rx: RTL and testbench
================================

Name: ef_i2s_tdm_rx

Overview:
Parametrised I2S/TDM receive master, the successor to the stereo-only I2S receiver.
- Generates SCK and WS, deserialises SDI into up to SLOTS 32-bit slots per frame, and formats each sample (size, sign extension).
- Pushes formatted samples with a slot tag into an internal FIFO read by the bus wrapper.
- Adds TDM mode, a per-slot enable mask, a correct-width FIFO level and a sticky overrun flag.

Parameters:
SLOTS, 8, maximum TDM slots per frame (power of 2, ≥2); TW = $clog2(SLOTS).
FIFO_AW, 5, FIFO depth = 2**FIFO_AW entries.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  enable; low = synchronous idle
mode  in  2  00 I2S (1-bit delay), 01 left-justified, 10 TDM/DSP-A, 11 reserved (treated as 00)
sck_prescaler  in  8  SCK half-period = sck_prescaler+1 clk
slot_count  in  TW+1  active slots in TDM (1..SLOTS; 0 treated as SLOTS); ignored in I2S/LJ (fixed 2)
slot_en  in  SLOTS  per-slot push enable (bit0 = left, bit1 = right)
sample_size  in  6  valid MSBs per slot, 1..32 (0 treated as 32)
sign_extend  in  1  sign-extend the right-aligned sample
sck  out  1  serial clock
ws  out  1  word select / frame sync
sdi  in  1  serial data
fifo_rd  in  1  pop (first-word fall-through)
fifo_rdata  out  32  head sample
fifo_rslot  out  TW  head slot tag
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_level  out  FIFO_AW+1  entries held, 0..2**FIFO_AW
fifo_threshold  in  FIFO_AW+1  level compare value
fifo_level_above  out  1  fifo_level > fifo_threshold
overrun  out  1  sticky: a push was dropped because the FIFO was full
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values:
  - sck=0, ws=0, prescaler=0, bit position=0, shift register=0.
  - FIFO empty, fifo_level=0, overrun=0, fifo_rdata/rslot don't-care.
- Clock generation:
  - While en: prescaler counts down; at 0 it reloads sck_prescaler and sck toggles.
  - SCK period = 2*(sck_prescaler+1) clk.
- en low:
  - Next clk: prescaler=0, sck=0, bit position=0, shift register cleared.
  - ws = position-0 value (0 for I2S/LJ, 1 for TDM).
  - FIFO contents and overrun retained.
  - Config inputs may change only while en=0.
- Frame geometry:
  - Frame bit position p advances on each SCK falling edge.
  - Frame length L = 64 (I2S/LJ) or slot_count*32 (TDM); p wraps to 0 after L-1.
- WS output (registered, updated at SCK falling edge to the value for the new p):
  - I2S/LJ: ws=0 for p in 0..31, ws=1 for p in 32..63.
  - TDM: ws=1 only at p=0.
- Data delay d = 1 (I2S, TDM) or 0 (LJ). MSB of slot s occurs at p = s*32+d (mod L).
- Capture:
  - sdi is sampled on the clk cycle sck goes 0→1 and shifted MSB-first into a 32-bit register.
  - Receive position r = (p-d) mod L.
  - When r[4:0]==31, the sample is complete for slot r>>5.
- Push:
  - Registered, occurs the clk cycle after the completing rising edge.
  - Pushed only if slot_en[slot]==1 and slot < active slots.
- Format:
  - data = sr >> (32-sample_size).
  - If sign_extend, bits [31:sample_size] are set to data bit sample_size-1.
  - sample_size=32 passes sr unchanged.
- FIFO:
  - Entry = {tag, data}.
  - A push while full is dropped and sets overrun; full is judged before a same-cycle pop, so a pop does not free room for that push.
  - fifo_rd while empty is ignored.
  - Simultaneous push and pop when neither full nor empty leaves level unchanged.
  - Level, full and empty update on the same edge as the pointers.
  - overrun set takes priority over overrun_clr in the same cycle.
- No slot sees a partial sample after en rises: the first push is for slot 0 after one full slot has been received. In I2S mode the last bit of slot 1 wraps into p=0 of the next frame.

Decomposition:
- Package ef_i2s_pkg:
  - mode constants MODE_I2S=2'b00, MODE_LJ=2'b01, MODE_TDM=2'b10.
  - SLOT_BITS=32.
  - Function sample_fmt(sr, size, sext).
- Sub-module ef_i2s_fwft_fifo (DW, AW): first-word fall-through FIFO with AW+1-bit level, full/empty registered, write gated by ~full.
- The top level holds the clock generator, frame counter, shift register, formatter and overrun logic.

Test Plan:
- I2S, prescaler=1, sample_size=24, sign_extend=1, slot_en=2'b11; left word 0x80_0001xx, right 0x12_3456xx.
  → FIFO gets {0, 0xFF800001} then {1, 0x00123456}.
  → SCK period 4 clk; ws falls one SCK before the left MSB.
- LJ, same words, sample_size=16, sign_extend=0.
  → {0, 0x00008000}, {1, 0x00001234}.
  → ws edge coincident with the MSB; push 1 clk after the 32nd rising edge.
- TDM, slot_count=4, slot_en=4'b1010, slot s carries 0x0000000s.
  → per frame only {1, 1}, {3, 3}.
  → ws high for exactly one SCK at p=0; frame = 128 SCK.
- FIFO_AW=2, run I2S with no reads for 3 frames.
  → level reaches 4, fifo_full=1, overrun=1, later samples dropped, head still the first left sample.
  → overrun_clr returns overrun to 0.
- Threshold 2: pop and push in the same cycle at level 3.
  → level stays 3, fifo_level_above=1; one pop to level 2 → 0.
- Deassert en mid-slot, then assert rst_n=0 mid-frame.
  → after en=0: sck=0 next cycle, no partial push, FIFO kept.
  → after reset: all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/ef_i2s_tdm_rx_pkg.sv
// Shared constants and the sample formatter for the I2S/TDM receiver.
package ef_i2s_pkg;
  localparam logic [1:0] MODE_I2S = 2'b00;
  localparam logic [1:0] MODE_LJ  = 2'b01;
  localparam logic [1:0] MODE_TDM = 2'b10;
  localparam int SLOT_BITS = 32;

  // Right-align the top `size` bits of a slot, optionally sign-extending.
  function automatic logic [31:0] sample_fmt(input logic [31:0] sr, input logic [5:0] size,
                                             input logic sext);
    logic [5:0]  sz;
    logic [31:0] d, mask;
    sz = (size == 6'd0 || size > 6'd32) ? 6'd32 : size;
    d = sr >> (6'd32 - sz);
    mask = '1;
    if (sz != 6'd32) begin
      mask = (32'd1 << sz) - 32'd1;
      if (sext && d[sz[4:0] - 5'd1]) d = d | ~mask;
    end
    return d;
  endfunction
endpackage

// File: rtl/ef_i2s_tdm_rx_if.sv
// FIFO read side of the receiver, as seen by the bus wrapper.
interface ef_i2s_tdm_rx_if #(parameter int SLOTS = 8, parameter int FIFO_AW = 5);
  localparam int TW = $clog2(SLOTS);
  logic              fifo_rd;
  logic [31:0]       fifo_rdata;
  logic [TW-1:0]     fifo_rslot;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_AW:0]  fifo_level;
  logic [FIFO_AW:0]  fifo_threshold;
  logic              fifo_level_above;

  modport master (output fifo_rd, fifo_threshold,
                  input  fifo_rdata, fifo_rslot, fifo_empty, fifo_full, fifo_level, fifo_level_above);
  modport slave  (input  fifo_rd, fifo_threshold,
                  output fifo_rdata, fifo_rslot, fifo_empty, fifo_full, fifo_level, fifo_level_above);
endinterface

// File: rtl/ef_i2s_tdm_rx_fifo.sv
// First-word fall-through FIFO; level/full/empty are registered with the pointers.
module ef_i2s_fwft_fifo #(
  parameter int DW = 34,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          we, re;
  logic [AW:0]   level_nx;

  // Full is judged on the registered flag, so a same-cycle pop never makes room.
  assign we    = push & ~full;
  assign re    = pop & ~empty;
  assign rdata = mem[rp];

  always_comb begin
    level_nx = level;
    if (we && !re)      level_nx = level + 1'b1;
    else if (!we && re) level_nx = level - 1'b1;
  end

  always_ff @(posedge clk)
    if (we) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      level <= level_nx;
      empty <= (level_nx == '0);
      full  <= (level_nx == DEPTH_L);
    end
  end
endmodule

// File: rtl/ef_i2s_tdm_rx.sv
// I2S/LJ/TDM receive master: SCK/WS generation, deserialiser, formatter, sample FIFO.
module ef_i2s_tdm_rx import ef_i2s_pkg::*; #(
  parameter int SLOTS   = 8,
  parameter int FIFO_AW = 5,
  localparam int TW     = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [7:0]       sck_prescaler,
  input  logic [TW:0]      slot_count,
  input  logic [SLOTS-1:0] slot_en,
  input  logic [5:0]       sample_size,
  input  logic             sign_extend,
  output logic             sck,
  output logic             ws,
  input  logic             sdi,
  ef_i2s_tdm_rx_if.slave   fif,
  output logic             overrun,
  input  logic             overrun_clr
);
  localparam int PW = TW + $clog2(SLOT_BITS);

  logic [7:0]     presc;
  logic [PW-1:0]  p, p_nx, r, lm1;
  logic [31:0]    sr, sr_nx;
  logic           is_tdm, is_lj, dly, tick, rise, fall, armed, cmpl, ws_nx;
  logic [TW:0]    active;
  logic [TW-1:0]  slot;
  logic           push_vld;
  logic [31:0]    push_data;
  logic [TW-1:0]  push_tag;
  logic [TW+31:0] head;

  assign is_tdm = (mode == MODE_TDM);
  assign is_lj  = (mode == MODE_LJ);
  assign dly    = ~is_lj;
  assign active = !is_tdm ? (TW+1)'(2) : (slot_count == '0 ? (TW+1)'(SLOTS) : slot_count);
  assign lm1    = PW'({active, 5'b0} - 1'b1);

  assign tick  = (presc == 8'd0);
  assign rise  = tick & ~sck;
  assign fall  = tick & sck;
  assign p_nx  = (p == lm1) ? '0 : p + 1'b1;
  assign ws_nx = is_tdm ? (p_nx == '0) : p_nx[5];
  // Receive position lags the frame position by the data delay.
  assign r     = (dly && p == '0) ? lm1 : p - PW'(dly);
  assign slot  = r[PW-1:5];
  assign sr_nx = {sr[30:0], sdi};
  // armed blocks a push until a slot has been received from its MSB.
  assign cmpl  = rise && (r[4:0] == 5'h1f) && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      p         <= '0;
      sr        <= '0;
      armed     <= 1'b0;
      push_vld  <= 1'b0;
      push_data <= '0;
      push_tag  <= '0;
    end else if (!en) begin
      presc    <= '0;
      sck      <= 1'b0;
      ws       <= is_tdm;
      p        <= '0;
      sr       <= '0;
      armed    <= 1'b0;
      push_vld <= 1'b0;
    end else begin
      presc    <= tick ? sck_prescaler : presc - 8'd1;
      push_vld <= 1'b0;
      if (tick) sck <= ~sck;
      if (fall) begin
        p  <= p_nx;
        ws <= ws_nx;
      end
      if (rise) begin
        sr <= sr_nx;
        if (r[4:0] == 5'd0) armed <= 1'b1;
        if (cmpl && slot_en[slot] && ({1'b0, slot} < active)) begin
          push_vld  <= 1'b1;
          push_data <= sample_fmt(sr_nx, sample_size, sign_extend);
          push_tag  <= slot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overrun <= 1'b0;
    else if (push_vld && fif.fifo_full) overrun <= 1'b1;
    else if (overrun_clr)           overrun <= 1'b0;
  end

  ef_i2s_fwft_fifo #(.DW(TW+32), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_vld),
    .wdata ({push_tag, push_data}),
    .pop   (fif.fifo_rd),
    .rdata (head),
    .empty (fif.fifo_empty),
    .full  (fif.fifo_full),
    .level (fif.fifo_level)
  );

  assign fif.fifo_rslot       = head[TW+31:32];
  assign fif.fifo_rdata       = head[31:0];
  assign fif.fifo_level_above = (fif.fifo_level > fif.fifo_threshold);
endmodule

// File: tb/tb_ef_i2s_tdm_rx.sv
// Directed bench for ef_i2s_tdm_rx: a serial source follows SCK, samples are checked at the FIFO.
module tb_ef_i2s_tdm_rx;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] presc = 8'd1;
  logic [2:0] slot_count = 3'd0;
  logic [3:0] slot_en = 4'b0011;
  logic [5:0] size = 6'd24;
  logic sext = 1'b1, sdi = 1'b0, overrun_clr = 1'b0, tb_rd = 1'b0, mon_rd = 1'b0;
  logic [2:0] thr = 3'd0;
  wire sck, ws, overrun;

  ef_i2s_tdm_rx_if #(.SLOTS(4), .FIFO_AW(2)) fif();
  assign fif.fifo_rd = tb_rd | mon_rd;
  assign fif.fifo_threshold = thr;

  ef_i2s_tdm_rx #(.SLOTS(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sck_prescaler(presc),
    .slot_count(slot_count), .slot_en(slot_en), .sample_size(size), .sign_extend(sext),
    .sck(sck), .ws(ws), .sdi(sdi), .fif(fif), .overrun(overrun), .overrun_clr(overrun_clr));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] words [4];
  int L_tb = 64, dd = 1;
  bit tdm = 1'b0;

  // source/monitor state
  int q = 0, rr = 0, cyc = 0, rise_cnt = 0, last_rise = 0, per = 0, r32_cyc = 0, ne_cyc = 0;
  int ws_bad = 0, ws_rise = 0, frame = 0, hi = 0, lvl_after = 0;
  bit sck_p = 0, ws_p = 0, empty_p = 1, rise = 0, pop_arm = 0, pop_done = 0, above_after = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_rd) begin
      lvl_after = int'(fif.fifo_level);
      above_after = fif.fifo_level_above;
      mon_rd = 1'b0;
      pop_done = 1'b1;
    end
    if (!en || !rst_n) begin
      q = 0; sck_p = 0; rise_cnt = 0; ne_cyc = 0;
    end else begin
      if (sck_p && !sck) q = (q == L_tb - 1) ? 0 : q + 1;
      rise = !sck_p && sck;
      if (rise) begin
        rise_cnt++;
        if (rise_cnt == 3) per = cyc - last_rise;
        last_rise = cyc;
        if (rise_cnt == 32) r32_cyc = cyc;
      end
      if (empty_p && !fif.fifo_empty && ne_cyc == 0) ne_cyc = cyc;
      if (ws !== (tdm ? (q == 0) : q[5])) ws_bad++;
      rr = (q - dd + L_tb) % L_tb;
      if (pop_arm && rise && rise_cnt > 1 && rr % 32 == 31) begin
        mon_rd = 1'b1;
        pop_arm = 1'b0;
      end
      if (ws && !ws_p) begin frame = cyc - ws_rise; ws_rise = cyc; end
      if (!ws && ws_p) hi = cyc - ws_rise;
      sck_p = sck;
    end
    ws_p = ws;
    empty_p = fif.fifo_empty;
    rr = (q - dd + L_tb) % L_tb;
    sdi = words[rr / 32][31 - rr % 32];
  end

  task automatic pop_chk(input string tag, input logic [1:0] es, input logic [31:0] ed);
    int n = 0;
    while (fif.fifo_empty && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s: no sample within 3000 cycles", tag);
    end else begin
      chk(tag, {fif.fifo_rslot, fif.fifo_rdata}, {es, ed});
      tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
    end
  endtask

  task automatic stop_drain();
    en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16 && !fif.fifo_empty; i++) begin
      tb_rd = 1'b1; @(negedge clk);
    end
    tb_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    words[0] = 32'h800001AB; words[1] = 32'h123456CD; words[2] = 0; words[3] = 0;
    repeat (3) @(negedge clk);
    chk("rst_level_async", fif.fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_empty", fif.fifo_empty, 1);
    chk("rst_full", fif.fifo_full, 0);
    chk("rst_level", fif.fifo_level, 0);
    chk("rst_above", fif.fifo_level_above, 0);
    chk("rst_overrun", overrun, 0);

    // I2S, 24-bit signed
    repeat (2) @(negedge clk);
    ws_bad = 0; en = 1'b1;
    pop_chk("i2s_l0", 2'd0, 32'hFF800001);
    pop_chk("i2s_r0", 2'd1, 32'h00123456);
    pop_chk("i2s_l1", 2'd0, 32'hFF800001);
    pop_chk("i2s_r1", 2'd1, 32'h00123456);
    stop_drain();
    chk("i2s_sck_period", per, 4);
    chk("i2s_ws", ws_bad, 0);

    // Left-justified, 16-bit unsigned
    mode = 2'b01; size = 6'd16; sext = 1'b0; dd = 0;
    repeat (2) @(negedge clk);
    ws_bad = 0; en = 1'b1;
    pop_chk("lj_l0", 2'd0, 32'h00008000);
    pop_chk("lj_r0", 2'd1, 32'h00001234);
    chk("lj_push_lat", ne_cyc - r32_cyc, 1);
    stop_drain();
    chk("lj_ws", ws_bad, 0);

    // TDM, 4 slots, slots 1 and 3 enabled
    mode = 2'b10; slot_count = 3'd4; slot_en = 4'b1010; size = 6'd0; dd = 1; L_tb = 128; tdm = 1'b1;
    for (int s = 0; s < 4; s++) words[s] = s;
    repeat (3) @(negedge clk);
    chk("tdm_idle_ws", ws, 1);
    ws_bad = 0; en = 1'b1;
    pop_chk("tdm_s1a", 2'd1, 32'd1);
    pop_chk("tdm_s3a", 2'd3, 32'd3);
    pop_chk("tdm_s1b", 2'd1, 32'd1);
    pop_chk("tdm_s3b", 2'd3, 32'd3);
    repeat (20) @(negedge clk);
    chk("tdm_frame", frame, 512);
    chk("tdm_ws_hi", hi, 4);
    stop_drain();
    chk("tdm_ws", ws_bad, 0);

    // Overflow with a 4-entry FIFO
    mode = 2'b00; slot_count = 3'd0; slot_en = 4'b0011; size = 6'd24; sext = 1'b1;
    L_tb = 64; tdm = 1'b0; thr = 3'd2;
    words[0] = 32'h800001AB; words[1] = 32'h123456CD;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (800) @(negedge clk);
    chk("ovf_level", fif.fifo_level, 4);
    chk("ovf_full", fif.fifo_full, 1);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_head", {fif.fifo_rslot, fif.fifo_rdata}, {2'd0, 32'hFF800001});
    chk("ovf_above", fif.fifo_level_above, 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
    chk("ovf_clr", overrun, 0);
    chk("ovf_keep", fif.fifo_level, 4);

    // Same-cycle push and pop at level 3
    tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
    chk("pp_level3", fif.fifo_level, 3);
    pop_arm = 1'b1; pop_done = 1'b0; en = 1'b1;
    for (int n = 0; n < 2000 && !pop_done; n++) @(negedge clk);
    en = 1'b0;
    chk("pp_done", pop_done, 1);
    chk("pp_level", lvl_after, 3);
    chk("pp_above", above_after, 1);
    repeat (2) @(negedge clk);
    tb_rd = 1'b1; @(negedge clk); tb_rd = 1'b0;
    chk("pp_level2", fif.fifo_level, 2);
    chk("pp_above2", fif.fifo_level_above, 0);

    // en dropped mid-slot, then reset mid-frame
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int n = 0; n < 500 && rise_cnt < 20; n++) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("off_sck", sck, 0);
    repeat (300) @(negedge clk);
    chk("off_keep", fif.fifo_level, 2);
    chk("off_ws", ws, 0);
    en = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", fif.fifo_empty, 1);
    @(negedge clk);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_ws", ws, 0);
    chk("mid_rst_level", fif.fifo_level, 0);
    chk("mid_rst_full", fif.fifo_full, 0);
    chk("mid_rst_overrun", overrun, 0);
    en = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
